// File: rtl/syn_down_counter.sv
// Purpose: loadable down-counter with prescaler, borrow out (BO) and an underflow pulse; cascades LSB->MSB via Et.
// Latency: load takes effect on its edge; first decrement on the TICK_DIV-th enabled edge after load; BO is combinational.
// Backpressure: none; Ep & Et low freezes count and prescaler exactly, so no progress is lost while stalled.
//
// Ports:
//   clk        in   1      clock, all state on posedge
//   reset      in   1      synchronous active-high clear of all state
//   Ep         in   1      parallel count enable
//   Et         in   1      trickle count enable, also gates BO
//   LOAD       in   1      active-low synchronous parallel load
//   i_preset   in   WIDTH  load value
//   o_Q        out  WIDTH  current count
//   BO         out  1      borrow out: (o_Q == 0) & Et
//   o_tc_pulse out  1      registered one-cycle pulse on each underflow step
module syn_down_counter #(
    parameter int WIDTH       = 4,
    parameter int TICK_DIV    = 1000,
    parameter int AUTO_RELOAD = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Ep,
    input  logic             Et,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] i_preset,
    output logic [WIDTH-1:0] o_Q,
    output logic             BO,
    output logic             o_tc_pulse
);

    // Prescaler terminal value; the prescaler is always 16 bits wide.
    localparam logic [15:0] PRE_LAST = 16'(TICK_DIV - 1);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] reload;
    logic [15:0]      pre;
    logic             tc;

    wire enable = Ep & Et;

    always_ff @(posedge clk) begin
        if (reset) begin
            q      <= '0;
            reload <= '0;
            pre    <= '0;
            tc     <= 1'b0;
        end else if (!LOAD) begin
            // Load also restarts the prescaler so the first step is a full period away.
            q      <= i_preset;
            reload <= i_preset;
            pre    <= '0;
            tc     <= 1'b0;
        end else if (enable) begin
            if (pre == PRE_LAST) begin
                pre <= '0;
                if (q != '0) begin
                    q  <= q - WIDTH'(1);
                    tc <= 1'b0;
                end else begin
                    // Underflow: wrap to all-ones, or restart from the last loaded value.
                    q  <= (AUTO_RELOAD != 0) ? reload : {WIDTH{1'b1}};
                    tc <= 1'b1;
                end
            end else begin
                pre <= pre + 16'd1;
                tc  <= 1'b0;
            end
        end else begin
            tc <= 1'b0;
        end
    end

    assign o_Q        = q;
    assign o_tc_pulse = tc;
    // Unregistered so the next cascade stage sees the borrow in the same cycle.
    assign BO         = (q == '0) & Et;

endmodule
